// File: rtl/noc_output_credit_arbiter_if.sv
// Signal bundle between the global switch-allocation inputs, switch traversal and the
// downstream credit-return path of one output port.
interface noc_output_credit_arbiter_if #(
  parameter int REQ_NUM  = 5,
  parameter int VC_NUM   = 4,
  parameter int VC_DEPTH = 2,
  parameter int QOS_W    = 4
);
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CNT_W = $clog2(VC_DEPTH + 1);

  logic [REQ_NUM-1:0]       req_vld_i;
  logic [REQ_NUM*VC_W-1:0]  req_vc_id_i;
  logic [REQ_NUM*QOS_W-1:0] req_qos_i;
  logic                     st_rdy_i;
  logic                     grant_vld_o;
  logic [REQ_NUM-1:0]       grant_oh_o;
  logic [VC_W-1:0]          grant_vc_id_o;
  logic                     crd_rtn_vld_i;
  logic [VC_W-1:0]          crd_rtn_vc_id_i;
  logic [VC_NUM*CNT_W-1:0]  crd_cnt_o;
  logic                     crd_err_o;

  modport master (
    output req_vld_i, req_vc_id_i, req_qos_i, st_rdy_i, crd_rtn_vld_i, crd_rtn_vc_id_i,
    input  grant_vld_o, grant_oh_o, grant_vc_id_o, crd_cnt_o, crd_err_o
  );

  modport slave (
    input  req_vld_i, req_vc_id_i, req_qos_i, st_rdy_i, crd_rtn_vld_i, crd_rtn_vc_id_i,
    output grant_vld_o, grant_oh_o, grant_vc_id_o, crd_cnt_o, crd_err_o
  );
endinterface

// File: rtl/noc_output_credit_arbiter.sv
// Output-port switch allocator: per-VC credit counters, QoS-first arbitration with
// round-robin tie breaking, one zero-latency grant per cycle.
module noc_output_credit_arbiter #(
  parameter int REQ_NUM  = 5,
  parameter int VC_NUM   = 4,
  parameter int VC_DEPTH = 2,
  parameter int QOS_W    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  noc_output_credit_arbiter_if.slave    bus
);
  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [CNT_W-1:0]   crd_cnt [VC_NUM];
  logic [PTR_W-1:0]   ptr;
  logic               crd_err;

  logic [REQ_NUM-1:0] elig;
  logic [REQ_NUM-1:0] cand;
  logic [REQ_NUM-1:0] win_oh;
  logic [QOS_W-1:0]   max_qos;
  logic [PTR_W-1:0]   win_idx;
  logic [VC_W-1:0]    win_vc;
  logic               grant;
  logic               found;
  int                 scan_idx;
  logic [VC_NUM-1:0]  take;
  logic [VC_NUM-1:0]  give;

  // A requester is eligible only if its VC id names a real VC that still holds credit.
  always_comb begin
    // NOTE: every variable gets its default before any conditional write, so no latch is inferred.
    elig    = '0;
    cand    = '0;
    max_qos = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (bus.req_vld_i[i] && (bus.req_vc_id_i[i*VC_W +: VC_W] == VC_W'(v)) &&
            (crd_cnt[v] != '0)) begin
          elig[i] = 1'b1;
        end
      end
      if (elig[i] && (bus.req_qos_i[i*QOS_W +: QOS_W] > max_qos)) begin
        max_qos = bus.req_qos_i[i*QOS_W +: QOS_W];
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      cand[i] = elig[i] && (bus.req_qos_i[i*QOS_W +: QOS_W] == max_qos);
    end
  end

  // First top-QoS candidate found scanning upward from the pointer, with wrap.
  always_comb begin
    win_idx  = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= REQ_NUM) scan_idx = scan_idx - REQ_NUM;
      if (!found && cand[scan_idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    grant  = bus.st_rdy_i & (|elig);
    win_vc = bus.req_vc_id_i[win_idx*VC_W +: VC_W];
    win_oh = '0;
    if (grant) win_oh[win_idx] = 1'b1;
    for (int v = 0; v < VC_NUM; v++) begin
      take[v] = grant && (win_vc == VC_W'(v));
      give[v] = bus.crd_rtn_vld_i && (bus.crd_rtn_vc_id_i == VC_W'(v));
    end

    bus.grant_vld_o   = grant;
    bus.grant_oh_o    = win_oh;
    bus.grant_vc_id_o = grant ? win_vc : '0;
    bus.crd_err_o     = crd_err;
    bus.crd_cnt_o     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      bus.crd_cnt_o[v*CNT_W +: CNT_W] = crd_cnt[v];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the credit counters are a few flops, not a RAM, so each one is reset to full credit.
      for (int v = 0; v < VC_NUM; v++) crd_cnt[v] <= CNT_W'(VC_DEPTH);
      ptr     <= '0;
      crd_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      for (int v = 0; v < VC_NUM; v++) begin
        if (take[v] && !give[v]) begin
          crd_cnt[v] <= crd_cnt[v] - 1'b1;
        end else if (give[v] && !take[v]) begin
          if (crd_cnt[v] == CNT_W'(VC_DEPTH)) crd_err <= 1'b1;
          else                                crd_cnt[v] <= crd_cnt[v] + 1'b1;
        end
      end
      if (grant) ptr <= (win_idx == PTR_W'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_output_credit_arbiter.sv
// Self-checking bench for noc_output_credit_arbiter: directed scenarios plus randomized
// traffic compared against a credit/priority reference model.
module tb_noc_output_credit_arbiter;
  localparam int REQ_NUM  = 5;
  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 2;
  localparam int QOS_W    = 4;
  localparam int VC_W     = 2;
  localparam int CNT_W    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: credits per VC, round-robin start position, sticky error.
  int m_cnt [VC_NUM];
  int m_ptr;
  bit m_err;

  noc_output_credit_arbiter_if #(.REQ_NUM(REQ_NUM), .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH),
                                 .QOS_W(QOS_W)) bus ();

  noc_output_credit_arbiter #(.REQ_NUM(REQ_NUM), .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH),
                              .QOS_W(QOS_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int cnt_of(input int v);
    return int'(bus.crd_cnt_o[v*CNT_W +: CNT_W]);
  endfunction

  task automatic clear_inputs();
    bus.req_vld_i       = '0;
    bus.req_vc_id_i     = '0;
    bus.req_qos_i       = '0;
    bus.st_rdy_i        = 1'b0;
    bus.crd_rtn_vld_i   = 1'b0;
    bus.crd_rtn_vc_id_i = '0;
  endtask

  task automatic set_req(input int i, input bit v, input int vc, input int q);
    bus.req_vld_i[i]                 = v;
    bus.req_vc_id_i[i*VC_W +: VC_W]  = VC_W'(vc);
    bus.req_qos_i[i*QOS_W +: QOS_W]  = QOS_W'(q);
  endtask

  task automatic set_rtn(input bit v, input int vc);
    bus.crd_rtn_vld_i   = v;
    bus.crd_rtn_vc_id_i = VC_W'(vc);
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) m_cnt[v] = VC_DEPTH;
    m_ptr = 0;
    m_err = 1'b0;
  endtask

  // Best requester = highest qos, then smallest forward distance from the pointer.
  task automatic model_pick(output bit gv, output int win, output int wvc);
    int best_q, best_d, vc, q, d;
    bit any;
    best_q = -1; best_d = REQ_NUM; any = 1'b0; win = 0; wvc = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      vc = int'(bus.req_vc_id_i[i*VC_W +: VC_W]);
      q  = int'(bus.req_qos_i[i*QOS_W +: QOS_W]);
      if (bus.req_vld_i[i] && vc < VC_NUM && m_cnt[vc] > 0) begin
        d = (i - m_ptr + REQ_NUM) % REQ_NUM;
        if (q > best_q || (q == best_q && d < best_d)) begin
          best_q = q; best_d = d; win = i; wvc = vc; any = 1'b1;
        end
      end
    end
    gv = any && bus.st_rdy_i;
  endtask

  task automatic model_commit(input bit gv, input int win, input int wvc);
    int rv;
    if (gv) begin
      m_cnt[wvc] = m_cnt[wvc] - 1;
      m_ptr = (win + 1) % REQ_NUM;
    end
    if (bus.crd_rtn_vld_i) begin
      rv = int'(bus.crd_rtn_vc_id_i);
      if (rv < VC_NUM) begin
        if (m_cnt[rv] == VC_DEPTH) m_err = 1'b1;
        else                       m_cnt[rv] = m_cnt[rv] + 1;
      end
    end
  endtask

  // Advance one clock keeping the model in lock step; returns at the falling edge.
  task automatic next_cycle();
    bit gv; int w, wvc;
    model_pick(gv, w, wvc);
    @(posedge clk);
    model_commit(gv, w, wvc);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    model_reset();
    #3;
    n_checks++; if (bus.grant_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_low_grant_vld: got %b want 0", bus.grant_vld_o); end
    n_checks++; if (bus.grant_oh_o !== 5'b00000) begin n_fail++; $display("FAIL rst_low_grant_oh: got %b want 00000", bus.grant_oh_o); end
    n_checks++; if (bus.grant_vc_id_o !== 2'd0) begin n_fail++; $display("FAIL rst_low_grant_vc: got %0d want 0", bus.grant_vc_id_o); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int v = 0; v < VC_NUM; v++) begin
      n_checks++; if (cnt_of(v) !== 2) begin n_fail++; $display("FAIL rst_cnt[%0d]: got %0d want 2", v, cnt_of(v)); end
    end
    n_checks++; if (bus.grant_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_grant_vld: got %b want 0", bus.grant_vld_o); end
    n_checks++; if (bus.crd_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.crd_err_o); end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 2, 4, 0, 2, 4};
    int vc_of   [5] = '{0, 0, 1, 0, 2};
    logic [REQ_NUM-1:0] e;
    apply_reset();
    bus.st_rdy_i = 1'b1;
    set_req(0, 1'b1, 0, 3);
    set_req(2, 1'b1, 1, 3);
    set_req(4, 1'b1, 2, 3);
    for (int k = 0; k < 6; k++) begin
      set_rtn(1'b1, vc_of[exp_seq[k]]);
      #1;
      e = '0;
      e[exp_seq[k]] = 1'b1;
      n_checks++; if (bus.grant_oh_o !== e) begin n_fail++; $display("FAIL rr_oh step %0d: got %b want %b", k, bus.grant_oh_o, e); end
      n_checks++; if (bus.grant_vc_id_o !== VC_W'(vc_of[exp_seq[k]])) begin n_fail++; $display("FAIL rr_vc step %0d: got %0d want %0d", k, bus.grant_vc_id_o, vc_of[exp_seq[k]]); end
      next_cycle();
    end
    clear_inputs();
    #1;
    for (int v = 0; v < 3; v++) begin
      n_checks++; if (cnt_of(v) !== 2) begin n_fail++; $display("FAIL rr_cnt[%0d]: got %0d want 2", v, cnt_of(v)); end
    end
    n_checks++; if (bus.crd_err_o !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", bus.crd_err_o); end
  endtask

  task automatic test_qos_priority();
    apply_reset();
    bus.st_rdy_i = 1'b1;
    set_req(1, 1'b1, 0, 2);
    set_req(3, 1'b1, 1, 9);
    #1;
    n_checks++; if (bus.grant_oh_o !== 5'b01000) begin n_fail++; $display("FAIL qos_oh: got %b want 01000", bus.grant_oh_o); end
    next_cycle();
    // With the pointer now at 4, an equal-qos tie between 3 and 4 goes to 4.
    clear_inputs();
    bus.st_rdy_i = 1'b1;
    set_req(3, 1'b1, 1, 5);
    set_req(4, 1'b1, 2, 5);
    #1;
    n_checks++; if (bus.grant_oh_o !== 5'b10000) begin n_fail++; $display("FAIL qos_ptr_oh: got %b want 10000", bus.grant_oh_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_credit_exhaustion();
    apply_reset();
    bus.st_rdy_i = 1'b1;
    set_req(0, 1'b1, 1, 0);
    #1;
    n_checks++; if (bus.grant_vld_o !== 1'b1) begin n_fail++; $display("FAIL exh_c1_vld: got %b want 1", bus.grant_vld_o); end
    n_checks++; if (cnt_of(1) !== 2) begin n_fail++; $display("FAIL exh_c1_cnt: got %0d want 2", cnt_of(1)); end
    next_cycle();
    #1;
    n_checks++; if (bus.grant_vld_o !== 1'b1) begin n_fail++; $display("FAIL exh_c2_vld: got %b want 1", bus.grant_vld_o); end
    n_checks++; if (cnt_of(1) !== 1) begin n_fail++; $display("FAIL exh_c2_cnt: got %0d want 1", cnt_of(1)); end
    next_cycle();
    set_rtn(1'b1, 1);
    #1;
    n_checks++; if (bus.grant_vld_o !== 1'b0) begin n_fail++; $display("FAIL exh_c3_vld: got %b want 0", bus.grant_vld_o); end
    n_checks++; if (cnt_of(1) !== 0) begin n_fail++; $display("FAIL exh_c3_cnt: got %0d want 0", cnt_of(1)); end
    next_cycle();
    set_rtn(1'b0, 0);
    #1;
    n_checks++; if (bus.grant_oh_o !== 5'b00001) begin n_fail++; $display("FAIL exh_c4_oh: got %b want 00001", bus.grant_oh_o); end
    n_checks++; if (cnt_of(1) !== 1) begin n_fail++; $display("FAIL exh_c4_cnt: got %0d want 1", cnt_of(1)); end
    next_cycle();
    #1;
    n_checks++; if (cnt_of(1) !== 0) begin n_fail++; $display("FAIL exh_c5_cnt: got %0d want 0", cnt_of(1)); end
    clear_inputs();
  endtask

  task automatic test_grant_and_return();
    apply_reset();
    bus.st_rdy_i = 1'b1;
    set_req(0, 1'b1, 2, 4);
    #1;
    next_cycle();
    #1;
    n_checks++; if (cnt_of(2) !== 1) begin n_fail++; $display("FAIL gr_pre_cnt: got %0d want 1", cnt_of(2)); end
    set_rtn(1'b1, 2);
    #1;
    n_checks++; if (bus.grant_vld_o !== 1'b1) begin n_fail++; $display("FAIL gr_vld: got %b want 1", bus.grant_vld_o); end
    n_checks++; if (bus.grant_vc_id_o !== 2'd2) begin n_fail++; $display("FAIL gr_vc: got %0d want 2", bus.grant_vc_id_o); end
    next_cycle();
    clear_inputs();
    #1;
    n_checks++; if (cnt_of(2) !== 1) begin n_fail++; $display("FAIL gr_post_cnt: got %0d want 1", cnt_of(2)); end
    n_checks++; if (bus.crd_err_o !== 1'b0) begin n_fail++; $display("FAIL gr_err: got %b want 0", bus.crd_err_o); end
  endtask

  task automatic test_overflow_backpressure();
    apply_reset();
    set_rtn(1'b1, 0);
    #1;
    n_checks++; if (bus.crd_err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_before_err: got %b want 0", bus.crd_err_o); end
    next_cycle();
    set_rtn(1'b0, 0);
    #1;
    n_checks++; if (cnt_of(0) !== 2) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 2", cnt_of(0)); end
    n_checks++; if (bus.crd_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", bus.crd_err_o); end
    next_cycle();
    #1;
    n_checks++; if (bus.crd_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.crd_err_o); end
    bus.st_rdy_i = 1'b0;
    set_req(0, 1'b1, 1, 7);
    set_req(2, 1'b1, 3, 7);
    #1;
    n_checks++; if (bus.grant_vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_vld: got %b want 0", bus.grant_vld_o); end
    n_checks++; if (bus.grant_oh_o !== 5'b00000) begin n_fail++; $display("FAIL bp_oh: got %b want 00000", bus.grant_oh_o); end
    n_checks++; if (bus.grant_vc_id_o !== 2'd0) begin n_fail++; $display("FAIL bp_vc: got %0d want 0", bus.grant_vc_id_o); end
    next_cycle();
    #1;
    n_checks++; if (cnt_of(1) !== 2) begin n_fail++; $display("FAIL bp_cnt1: got %0d want 2", cnt_of(1)); end
    n_checks++; if (cnt_of(3) !== 2) begin n_fail++; $display("FAIL bp_cnt3: got %0d want 2", cnt_of(3)); end
    bus.st_rdy_i = 1'b1;
    #1;
    n_checks++; if (bus.grant_oh_o !== 5'b00001) begin n_fail++; $display("FAIL bp_ptr_oh: got %b want 00001", bus.grant_oh_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.st_rdy_i = 1'b1;
    set_req(0, 1'b1, 0, 1);
    set_req(1, 1'b1, 3, 1);
    #1;
    next_cycle();
    next_cycle();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    for (int v = 0; v < VC_NUM; v++) begin
      n_checks++; if (cnt_of(v) !== 2) begin n_fail++; $display("FAIL midrst_cnt[%0d]: got %0d want 2", v, cnt_of(v)); end
    end
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    bus.st_rdy_i = 1'b1;
    set_req(1, 1'b1, 0, 1);
    set_req(3, 1'b1, 3, 1);
    #1;
    n_checks++; if (bus.grant_oh_o !== 5'b00010) begin n_fail++; $display("FAIL midrst_ptr_oh: got %b want 00010", bus.grant_oh_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    bit gv; int w, wvc, rv;
    logic [REQ_NUM-1:0] e;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      bus.st_rdy_i = $urandom_range(0, 9) < 8;
      rv = $urandom_range(0, 3);
      if (m_cnt[rv] < VC_DEPTH) set_rtn($urandom_range(0, 1) == 1, rv);
      else                      set_rtn($urandom_range(0, 19) == 0, rv);
      #1;
      model_pick(gv, w, wvc);
      e = '0;
      if (gv) e[w] = 1'b1;
      n_checks++; if (bus.grant_vld_o !== gv) begin n_fail++; $display("FAIL rnd_vld cyc %0d: got %b want %b", c, bus.grant_vld_o, gv); end
      n_checks++; if (bus.grant_oh_o !== e) begin n_fail++; $display("FAIL rnd_oh cyc %0d: got %b want %b", c, bus.grant_oh_o, e); end
      n_checks++; if (bus.grant_vc_id_o !== VC_W'(gv ? wvc : 0)) begin n_fail++; $display("FAIL rnd_vc cyc %0d: got %0d want %0d", c, bus.grant_vc_id_o, gv ? wvc : 0); end
      for (int v = 0; v < VC_NUM; v++) begin
        n_checks++; if (cnt_of(v) !== m_cnt[v]) begin n_fail++; $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d", v, c, cnt_of(v), m_cnt[v]); end
      end
      n_checks++; if (bus.crd_err_o !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %b want %b", c, bus.crd_err_o, m_err); end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_qos_priority();
    test_credit_exhaustion();
    test_grant_and_return();
    test_overflow_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
